// File: rtl/nios_system_pio_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM PIO slave between two masters.
// Optional locked-ownership mode is enabled by defining PIO_ARB_LOCK_EN.
module nios_system_pio_arbiter #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_chipselect,
  input  logic              m0_write_n,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_chipselect,
  input  logic              m1_write_n,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        grant
`ifdef PIO_ARB_LOCK_EN
  ,
  input  logic              m0_lock,
  input  logic              m1_lock
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state, state_nxt;
  logic   last_served;  // 0 = m0, 1 = m1
  logic   req0, req1, pick_m1;

`ifdef PIO_ARB_LOCK_EN
  logic lock_active;
  logic lock_owner;
`endif

  always_comb begin
    req0 = m0_chipselect;
    req1 = m1_chipselect;
`ifdef PIO_ARB_LOCK_EN
    if (lock_active) begin
      req0 = m0_chipselect & ~lock_owner;
      req1 = m1_chipselect &  lock_owner;
    end
`endif
    // On a tie the master that was not served last wins.
    pick_m1 = req1 & (~req0 | ~last_served);

    state_nxt = state;
    case (state)
      IDLE:    if (req0 | req1) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= '0;
      s_address    <= '0;
      s_chipselect <= 1'b0;
      s_write_n    <= 1'b1;
      s_writedata  <= '0;
      m0_readdata  <= '0;
      m1_readdata  <= '0;
      last_served  <= 1'b1;
`ifdef PIO_ARB_LOCK_EN
      lock_active  <= 1'b0;
      lock_owner   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant        <= pick_m1 ? 2'b10 : 2'b01;
            s_address    <= pick_m1 ? m1_address   : m0_address;
            s_write_n    <= pick_m1 ? m1_write_n   : m0_write_n;
            s_writedata  <= pick_m1 ? m1_writedata : m0_writedata;
            s_chipselect <= 1'b1;
          end
        end
        ACCESS: begin
          if (grant[1]) m1_readdata <= s_readdata;
          else          m0_readdata <= s_readdata;
          s_chipselect <= 1'b0;
          s_write_n    <= 1'b1;
        end
        DONE: begin
          last_served <= grant[1];
          grant       <= '0;
`ifdef PIO_ARB_LOCK_EN
          // While locked only the owner reaches DONE, so its lock input alone decides.
          lock_active <= grant[1] ? m1_lock : m0_lock;
          lock_owner  <= grant[1];
`endif
        end
        default: grant <= '0;
      endcase
    end
  end

  assign m0_waitrequest = !((state == DONE) && grant[0]);
  assign m1_waitrequest = !((state == DONE) && grant[1]);

endmodule

// File: tb/tb_nios_system_pio_arbiter.sv
// Bench for nios_system_pio_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter and slave.
`timescale 1ns/1ps
module tb_nios_system_pio_arbiter;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] m_addr [2];
  logic              cs     [2];
  logic              wn     [2];
  logic [DATA_W-1:0] wd     [2];
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_writedata, s_readdata;
  logic              m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n;
  logic [ADDR_W-1:0] s_address;
  logic [1:0]        grant;
`ifdef PIO_ARB_LOCK_EN
  logic              lk [2];
`endif

  always #5 clk = ~clk;

  nios_system_pio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m_addr[0]), .m0_chipselect(cs[0]), .m0_write_n(wn[0]), .m0_writedata(wd[0]),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m_addr[1]), .m1_chipselect(cs[1]), .m1_write_n(wn[1]), .m1_writedata(wd[1]),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .grant(grant)
`ifdef PIO_ARB_LOCK_EN
    , .m0_lock(lk[0]), .m1_lock(lk[1])
`endif
  );

  // Zero-wait PIO slave: four registers, combinational read, write on strobe.
  logic [DATA_W-1:0] smem [4];
  assign s_readdata = smem[s_address];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) smem[i] <= '0;
    end else if (s_chipselect && !s_write_n) begin
      smem[s_address] <= s_writedata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mcyc counts cycles into the current transaction (0 = free).
  int          mcyc, mw, mlast, m1_dones;
  logic [1:0]  ma;
  logic        mwn;
  logic [31:0] mwd;
  logic [31:0] mmem [4];
  logic [31:0] mrd  [2];
  bit          mrd_ok [2];
  bit          keep [2];
  bit          rnd_mode;
  bit          lock_act;
  int          lock_own;
  int          dut_order [$];

  task automatic model_reset();
    mcyc = 0; mw = 0; mlast = 1; lock_act = 0; lock_own = 0;
    for (int i = 0; i < 4; i++) mmem[i] = '0;
    for (int k = 0; k < 2; k++) begin mrd[k] = '0; mrd_ok[k] = 1; end
  endtask

  task automatic model_advance();
    bit r0, r1;
    r0 = cs[0]; r1 = cs[1];
    if (lock_act) begin
      if (lock_own == 0) r1 = 0; else r0 = 0;
    end
    case (mcyc)
      0: if (r0 || r1) begin
           mw  = (r0 && r1) ? (mlast == 1 ? 0 : 1) : (r0 ? 0 : 1);
           ma  = m_addr[mw]; mwn = wn[mw]; mwd = wd[mw];
           mcyc = 1;
         end
      1: begin
           if (!mwn) begin mmem[ma] = mwd; mrd_ok[mw] = 0; end
           else      begin mrd[mw] = mmem[ma]; mrd_ok[mw] = 1; end
           mcyc = 2;
         end
      default: begin
           mlast = mw;
`ifdef PIO_ARB_LOCK_EN
           lock_act = lk[mw]; lock_own = mw;
`endif
           mcyc = 0;
         end
    endcase
  endtask

  task automatic check_outputs();
    check("grant", {30'd0, grant}, mcyc == 0 ? 0 : (mw == 0 ? 1 : 2));
    check("s_chipselect", {31'd0, s_chipselect}, {31'd0, mcyc == 1});
    check("s_write_n", {31'd0, s_write_n}, mcyc == 1 ? {31'd0, mwn} : 1);
    check("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, !(mcyc == 2 && mw == 0)});
    check("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, !(mcyc == 2 && mw == 1)});
    if (mcyc == 1) begin
      check("s_address", {30'd0, s_address}, {30'd0, ma});
      check("s_writedata", s_writedata, mwd);
    end
    if (mrd_ok[0]) check("m0_readdata", m0_readdata, mrd[0]);
    if (mrd_ok[1]) check("m1_readdata", m1_readdata, mrd[1]);
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      if (!cs[k]) begin
        if ($urandom_range(2) == 0) begin
          cs[k] = 1; m_addr[k] = 2'($urandom); wn[k] = 1'($urandom);
          wd[k] = $urandom; keep[k] = ($urandom_range(3) == 0);
        end
      end else if (!(mcyc != 0 && mw == k)) begin
        // Waiting master may wiggle its request fields; only values at grant matter.
        if ($urandom_range(3) == 0) begin
          m_addr[k] = 2'($urandom); wn[k] = 1'($urandom); wd[k] = $urandom;
        end
      end else if ($urandom_range(7) == 0) begin
        cs[k] = 0;
      end
    end
  endtask

  task automatic tick();
    if (rnd_mode) drive_random();
    model_advance();
    @(negedge clk);
    check_outputs();
    if (!m0_waitrequest) dut_order.push_back(0);
    if (!m1_waitrequest) dut_order.push_back(1);
    if (mcyc == 2) begin
      if (mw == 1) m1_dones++;
      if (!keep[mw]) cs[mw] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    for (int k = 0; k < 2; k++) begin
      cs[k] = 0; wn[k] = 1; m_addr[k] = '0; wd[k] = '0; keep[k] = 0;
`ifdef PIO_ARB_LOCK_EN
      lk[k] = 0;
`endif
    end
    model_reset();
    dut_order.delete();
    m1_dones = 0;
    @(negedge clk);
    check("reset s_address", {30'd0, s_address}, 0);
    check("reset s_writedata", s_writedata, 0);
    check_outputs();
    reset_n = 1;
  endtask

  task automatic request(input int k, input logic w_n, input logic [1:0] a, input logic [31:0] d);
    cs[k] = 1; wn[k] = w_n; m_addr[k] = a; wd[k] = d;
  endtask

  initial begin
    rnd_mode = 0;

    // Single m0 write of 3 to address 0.
    do_reset();
    request(0, 1'b0, 2'd0, 32'h3);
    repeat (4) tick();
    check("single write completions", dut_order.size(), 1);
    check("single write owner", dut_order.size() > 0 ? dut_order[0] : 99, 0);

    // m0 sets address 0 to 2, then m1 reads it back.
    do_reset();
    request(0, 1'b0, 2'd0, 32'h2);
    repeat (3) tick();
    request(1, 1'b1, 2'd0, 32'h0);
    repeat (3) tick();
    check("m1 read value", m1_readdata, 32'h2);
    check("m0 readdata untouched", m0_readdata, 32'h0);

    // Continuous contention alternates m0, m1, ...
    do_reset();
    keep[0] = 1; keep[1] = 1;
    request(0, 1'b1, 2'd1, 32'h11);
    request(1, 1'b0, 2'd2, 32'h22);
    repeat (18) tick();
    check("contention count", dut_order.size(), 6);
    for (int i = 0; i < 6; i++)
      check("contention order", i < dut_order.size() ? dut_order[i] : 99, i % 2);

    // Reset pulse in the middle of an m1 write.
    do_reset();
    request(1, 1'b0, 2'd2, 32'hdead);
    tick();
    #2 reset_n = 0;
    #1 check("async s_chipselect", {31'd0, s_chipselect}, 0);
    check("async grant", {30'd0, grant}, 0);
    check("async m1_waitrequest", {31'd0, m1_waitrequest}, 1);
    cs[1] = 0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset_n = 1;
    dut_order.delete();
    request(0, 1'b1, 2'd2, 32'h0);
    request(1, 1'b1, 2'd2, 32'h0);
    repeat (3) tick();
    check("winner after reset", dut_order.size() > 0 ? dut_order[0] : 99, 0);
    check("written data lost", m0_readdata, 32'h0);

    // Per-master readdata isolation.
    do_reset();
    request(0, 1'b0, 2'd1, 32'h0);
    repeat (3) tick();
    request(1, 1'b0, 2'd0, 32'h1);
    repeat (3) tick();
    request(0, 1'b1, 2'd1, 32'h0);
    request(1, 1'b1, 2'd0, 32'h0);
    repeat (6) tick();
    check("m0 isolated read", m0_readdata, 32'h0);
    check("m1 isolated read", m1_readdata, 32'h1);

`ifdef PIO_ARB_LOCK_EN
    // m1 holds the lock for three transactions, releases on the fourth.
    do_reset();
    keep[0] = 1; keep[1] = 1; lk[1] = 1;
    request(1, 1'b1, 2'd3, 32'h0);
    tick();
    request(0, 1'b1, 2'd2, 32'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m1_dones == 3 && mcyc != 2) lk[1] = 0;
    end
    check("lock count", dut_order.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      check("lock order", i < dut_order.size() ? dut_order[i] : 99, i < 4 ? 1 : 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    rnd_mode = 1;
    repeat (3000) tick();
    rnd_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_pio_arbiter.md
Name: nios_system_pio_arbiter

Overview:
- Two-master arbiter that shares one Avalon-MM PIO slave (2-bit address, 32-bit data, zero-wait combinational readdata) between two masters: m0 (Nios data master) and m1 (hardware maze sequencer).
- Serialises accesses with round-robin priority and drives one registered single-cycle access into the slave.
- Returns read data and completes each transaction to its master with waitrequest.

Parameters:
- ADDR_W, 2, width of the slave address bus
- DATA_W, 32, width of the readdata and writedata buses

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_chipselect  in  1  master 0 request; held until waitrequest is low
- m0_write_n  in  1  master 0 direction: 0 = write, 1 = read
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data; valid while m0_waitrequest is low
- m0_waitrequest  out  1  master 0 stall
- m1_address, m1_chipselect, m1_write_n, m1_writedata, m1_readdata, m1_waitrequest  same as m0, for master 1
- s_address  out  ADDR_W  to slave
- s_chipselect  out  1  to slave
- s_write_n  out  1  to slave
- s_writedata  out  DATA_W  to slave
- s_readdata  in  DATA_W  from slave; combinational on s_address
- grant  out  2  one-hot current owner, for debug; 00 when idle

Behaviour:
- Reset values:
  - State is IDLE.
  - grant = 00, s_chipselect = 0, s_write_n = 1, s_address = 0, s_writedata = 0.
  - m0_readdata = m1_readdata = 0.
  - m0_waitrequest = m1_waitrequest = 1.
  - last_served = m1, so m0 wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No chipselect asserted: stay in IDLE.
  - Exactly one chipselect asserted: grant that master.
  - Both asserted: grant the master that is not last_served.
  - On a grant: latch the granted master's address, write_n and writedata into the s_* registers; set s_chipselect = 1; go to ACCESS.
- ACCESS (exactly one cycle):
  - The slave sees s_chipselect = 1 with stable signals; writes commit at this clock edge.
  - Capture s_readdata into the granted master's readdata register; capture on writes too, where the value is don't-care.
  - Set s_chipselect = 0 and s_write_n = 1; go to DONE.
- DONE (exactly one cycle):
  - The granted master's waitrequest is 0; the other master's is 1.
  - Update last_served to the granted master; clear grant; go to IDLE.
- waitrequest rule: mN_waitrequest = 0 only in DONE with grant = N; 1 at all other times, including when the master is idle.
- Latency: chipselect sampled in IDLE at cycle 0, slave strobe at cycle 1, waitrequest low at cycle 2. Throughput is one access per 3 cycles. Back-to-back contention alternates m0, m1, m0, ...
- readdata holds its value until that master's next read capture.
- Boundary conditions:
  - Master drops chipselect during ACCESS or DONE (protocol violation): the access still completes and the FSM returns to IDLE normally.
  - A master keeps chipselect high after its DONE cycle: this is treated as a new request in IDLE and competes under round-robin.
  - Non-granted master changes its address or data while waiting: it has no effect until that master is granted; values are latched at grant.
  - Reset asserted mid-ACCESS: s_chipselect drops asynchronously and the slave write is not guaranteed. All state returns to reset values.

Optional Feature:
- Macro: PIO_ARB_LOCK_EN.
- When defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master has lock = 1 in its DONE cycle, the arbiter enters locked mode for that master.
  - In locked mode, IDLE grants only that master; the other master waits indefinitely.
  - Locked mode clears when the owner completes a DONE cycle with lock = 0, or on reset.
  - last_served updates as normal.
- When undefined: the lock ports do not exist and arbitration is pure round-robin.

Test Plan:
- Reset, then m0 writes 0x00000003 to address 0 -> s_chipselect high for exactly 1 cycle, with s_writedata = 0x3 and s_write_n = 0, at cycle 1 -> m0_waitrequest low at cycle 2 only -> grant = 00 after.
- Slave readdata = 0x00000002; m1 reads address 0 -> m1_readdata = 0x2 with m1_waitrequest low 2 cycles after request; m0_readdata unchanged at 0.
- m0 and m1 both assert chipselect continuously for 6 transactions after reset -> completion order m0, m1, m0, m1, m0, m1; each transaction takes 3 cycles.
- reset_n pulsed low during ACCESS of an m1 write -> s_chipselect = 0 immediately; all outputs at reset values; next contention is won by m0.
- Both masters read while the slave returns different data per address (m0 at address 1 -> 0x0, m1 at address 0 -> 0x1) -> each master's readdata holds its own value and there is no cross-contamination.
- With PIO_ARB_LOCK_EN defined: m1 performs 3 transactions with m1_lock = 1 and then 1 with m1_lock = 0, while m0 requests throughout -> m0 is served only after m1's fourth DONE.
